fifo_ctl_flags: RTL and testbench

//  Parametrised single-clock FIFO, generalising the fixed 2-bit-pointer fifo to any DEPTH/DATA_WIDTH.

---
 rtl/fifo_ctl_flags.sv | 134 +++++++++++++
 tb/tb_fifo_ctl_flags.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctl_flags.sv
// ============================================================================
// Module      : fifo_ctl_flags
// Description : Parametrised single-clock FIFO with size/space counters,
//               almost-full/empty flags, flush, sticky error flags and
//               a registered read port with a valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctl_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1,
    localparam int PTR_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] dataIn_data,
    input  logic                  dataIn_en,
    output logic                  dataIn_wait,
    output logic [DATA_WIDTH-1:0] dataOut_data,
    input  logic                  dataOut_en,
    output logic                  dataOut_wait,
    output logic                  dataOut_vld,
    output logic [CNT_W-1:0]      size,
    output logic [CNT_W-1:0]      space,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      size_q, size_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  vld_q, vld_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake flags come from stored state only, never from the requests.
    assign dataIn_wait  = (size_q == DEPTH_C);
    assign dataOut_wait = (size_q == '0);

    assign wr_acc = dataIn_en  & ~dataIn_wait  & ~flush;
    assign rd_acc = dataOut_en & ~dataOut_wait & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        size_d   = size_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        ovf_d    = ovf_q | (dataIn_en & dataIn_wait);
        unf_d    = unf_q | (dataOut_en & dataOut_wait);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            size_d   = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths inside the array.
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
                dout_d   = mem[rd_ptr_q];
                vld_d    = 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                size_d = size_q + CNT_ONE;
            end else if (rd_acc && !wr_acc) begin
                size_d = size_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= dataIn_data;
        end
    end

    assign dataOut_data = dout_q;
    assign dataOut_vld  = vld_q;
    assign size         = size_q;
    assign space        = DEPTH_C - size_q;
    assign almost_full  = (size_q >= AF_C);
    assign almost_empty = (size_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctl_flags.sv
// ============================================================================
// Module      : tb_fifo_ctl_flags
// Description : Directed self-checking bench for fifo_ctl_flags (DEPTH 5 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctl_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=5 instance
    logic       a_rst_n, a_flush, a_wen, a_ren;
    logic [7:0] a_din;
    logic       a_iwait, a_owait, a_vld, a_af, a_ae, a_ovf, a_unf;
    logic [7:0] a_dout;
    logic [2:0] a_size, a_space;

    // DEPTH=4 instance
    logic       b_rst_n, b_flush, b_wen, b_ren;
    logic [7:0] b_din;
    logic       b_iwait, b_owait, b_vld, b_af, b_ae, b_ovf, b_unf;
    logic [7:0] b_dout;
    logic [2:0] b_size, b_space;

    fifo_ctl_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
        .dataIn_data(a_din), .dataIn_en(a_wen), .dataIn_wait(a_iwait),
        .dataOut_data(a_dout), .dataOut_en(a_ren), .dataOut_wait(a_owait),
        .dataOut_vld(a_vld), .size(a_size), .space(a_space),
        .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_ctl_flags #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
        .dataIn_data(b_din), .dataIn_en(b_wen), .dataIn_wait(b_iwait),
        .dataOut_data(b_dout), .dataOut_en(b_ren), .dataOut_wait(b_owait),
        .dataOut_vld(b_vld), .size(b_size), .space(b_space),
        .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_flush = 1'b0; a_wen = 1'b0; a_ren = 1'b0; a_din = '0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_din = '0;
        step();
        step();

        // Reset state
        chk("rst_size",   a_size,  0);
        chk("rst_space",  a_space, 5);
        chk("rst_iwait",  a_iwait, 0);
        chk("rst_owait",  a_owait, 1);
        chk("rst_ae",     a_ae,    1);
        chk("rst_af",     a_af,    0);
        chk("rst_ovf",    a_ovf,   0);
        chk("rst_unf",    a_unf,   0);
        chk("rst_vld",    a_vld,   0);
        chk("rst_dout",   a_dout,  0);
        a_rst_n = 1'b1;

        // T1: fill to full, then overflow
        a_wen = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a_din = 8'(i);
            step();
            chk("t1_size", a_size, i);
        end
        a_wen = 1'b0;
        chk("t1_iwait", a_iwait, 1);
        chk("t1_space", a_space, 0);
        chk("t1_af",    a_af,    1);
        chk("t1_ovf0",  a_ovf,   0);
        a_wen = 1'b1; a_din = 8'd6;
        step();
        a_wen = 1'b0;
        chk("t1_ovf",     a_ovf,  1);
        chk("t1_size_ov", a_size, 5);

        // T2: drain in order, then underflow
        a_ren = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t2_dout", a_dout, i);
            chk("t2_vld",  a_vld,  1);
        end
        a_ren = 1'b0;
        step();
        chk("t2_vld_idle", a_vld,   0);
        chk("t2_owait",    a_owait, 1);
        chk("t2_hold",     a_dout,  5);
        chk("t2_unf0",     a_unf,   0);
        a_ren = 1'b1;
        step();
        a_ren = 1'b0;
        chk("t2_unf",     a_unf, 1);
        chk("t2_unf_vld", a_vld, 0);

        // T3: steady size 2 with simultaneous read/write across pointer wrap
        a_wen = 1'b1;
        a_din = 8'd10; step();
        a_din = 8'd11; step();
        a_ren = 1'b1;
        for (int k = 0; k < 12; k++) begin
            a_din = 8'(12 + k);
            step();
            chk("t3_size", a_size, 2);
            chk("t3_dout", a_dout, 10 + k);
            chk("t3_vld",  a_vld,  1);
        end
        a_wen = 1'b0;
        step(); chk("t3_tail0", a_dout, 22);
        step(); chk("t3_tail1", a_dout, 23);
        a_ren = 1'b0;
        step();
        chk("t3_empty", a_size, 0);

        // T4: both requests while full, then while empty
        a_wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_din = 8'(31 + i);
            step();
        end
        a_din = 8'd99; a_ren = 1'b1;
        step();
        chk("t4_full_size", a_size, 4);
        chk("t4_full_dout", a_dout, 31);
        chk("t4_full_vld",  a_vld,  1);
        a_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_drain", a_dout, 32 + i);
        end
        a_wen = 1'b1; a_din = 8'd77;
        step();
        chk("t4_empty_size", a_size, 1);
        chk("t4_empty_vld",  a_vld,  0);
        chk("t4_empty_dout", a_dout, 35);
        a_wen = 1'b0;
        step();
        chk("t4_bypass_rd", a_dout, 77);
        a_ren = 1'b0;

        // T5: flush with sticky flag set and requests pending
        a_wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = 8'(41 + i);
            step();
        end
        a_wen = 1'b0;
        chk("t5_pre_size", a_size, 3);
        chk("t5_pre_ovf",  a_ovf,  1);
        a_flush = 1'b1; a_wen = 1'b1; a_ren = 1'b1; a_din = 8'd50;
        step();
        a_flush = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
        chk("t5_size",  a_size,  0);
        chk("t5_space", a_space, 5);
        chk("t5_ovf",   a_ovf,   0);
        chk("t5_unf",   a_unf,   0);
        chk("t5_vld",   a_vld,   0);
        chk("t5_dout",  a_dout,  77);
        a_wen = 1'b1; a_din = 8'd60;
        step();
        a_wen = 1'b0; a_ren = 1'b1;
        step();
        a_ren = 1'b0;
        chk("t5_new_dout", a_dout, 60);
        chk("t5_new_vld",  a_vld,  1);

        // T6: flag thresholds on DEPTH=4, then reset mid-stream
        b_rst_n = 1'b1;
        chk("t6_ae0", b_ae, 1);
        chk("t6_af0", b_af, 0);
        b_wen = 1'b1;
        b_din = 8'hA1; step(); chk("t6_ae1", b_ae, 1); chk("t6_af1", b_af, 0);
        b_din = 8'hA2; step(); chk("t6_ae2", b_ae, 0); chk("t6_af2", b_af, 0);
        b_din = 8'hA3; step(); chk("t6_ae3", b_ae, 0); chk("t6_af3", b_af, 1);
        b_din = 8'hA4; step(); chk("t6_ae4", b_ae, 0); chk("t6_af4", b_af, 1);
        chk("t6_iwait", b_iwait, 1);
        b_wen = 1'b0; b_ren = 1'b1;
        step();
        chk("t6_rd", b_dout, 8'hA1);
        b_rst_n = 1'b0; b_wen = 1'b1; b_din = 8'hEE;
        step();
        chk("t6_rst_size",  b_size,  0);
        chk("t6_rst_space", b_space, 4);
        chk("t6_rst_dout",  b_dout,  0);
        chk("t6_rst_vld",   b_vld,   0);
        chk("t6_rst_owait", b_owait, 1);
        chk("t6_rst_ae",    b_ae,    1);
        chk("t6_rst_af",    b_af,    0);
        b_rst_n = 1'b1; b_ren = 1'b0; b_din = 8'hB1;
        step();
        b_wen = 1'b0; b_ren = 1'b1;
        step();
        b_ren = 1'b0;
        chk("t6_after_rst", b_dout,  8'hB1);
        chk("t6_after_emp", b_owait, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
